// File: rtl/io_bus_led_bank.sv
// rtl/io_bus_led_bank.sv - bus-mapped LED data registers with per-byte blink
//
// Register window starting at BASE_ADDR:
//   offset 0..NUM_BYTES-1 : DATA[o]   (r/w) LED pattern for byte o
//   offset NUM_BYTES      : BLINK_EN  (r/w) bit i blinks byte i
//   offset NUM_BYTES+1    : STATUS    (r: {7'b0, phase}, any write restarts blink)
//
// Ports:
//   CLK       single clock, rising edge
//   RESET_N   asynchronous active-low reset
//   BUS_DATA  shared tri-state data bus (CPU drives on writes, block drives on reads)
//   BUS_ADDR  bus address
//   BUS_WE    1 = write cycle, 0 = read cycle
//   LEDs      registered LED drive, byte i at [8i+7:8i]

module io_bus_led_bank #(
   parameter logic [7:0] BASE_ADDR     = 8'hC0,
   parameter int         NUM_BYTES     = 2,
   parameter int         BLINK_DIV     = 25000000,
   parameter logic [7:0] RESET_PATTERN = 8'hA0
) (
   input  logic                   CLK,
   input  logic                   RESET_N,
   inout  wire  [7:0]             BUS_DATA,
   input  logic [7:0]             BUS_ADDR,
   input  logic                   BUS_WE,
   output logic [8*NUM_BYTES-1:0] LEDs
);

   localparam int              CNT_W      = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BLINK_DIV - 1);
   localparam logic [7:0]      OFF_BLINK  = 8'(NUM_BYTES);
   localparam logic [7:0]      OFF_STATUS = 8'(NUM_BYTES + 1);

   if (NUM_BYTES < 1 || NUM_BYTES > 8) begin : g_bad_num_bytes
      $error("io_bus_led_bank: NUM_BYTES must be 1..8");
   end
   if (BLINK_DIV < 2) begin : g_bad_blink_div
      $error("io_bus_led_bank: BLINK_DIV must be at least 2");
   end
   if (int'(BASE_ADDR) + NUM_BYTES + 1 > 255) begin : g_bad_window
      $error("io_bus_led_bank: register window runs past address 8'hFF");
   end

   logic [7:0]           data_q [NUM_BYTES];
   logic [NUM_BYTES-1:0] blink_en_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 phase_q;
   logic [7:0]           rd_latch_q;
   logic                 oe_q;

   logic [7:0] offset;
   logic       hit;
   logic       rd_hit;
   logic       wr_hit;
   logic [7:0] rd_val;

   // Offset wraps for addresses below the base, so the lower bound is
   // checked separately on the raw address.
   assign offset = BUS_ADDR - BASE_ADDR;
   assign hit    = (BUS_ADDR >= BASE_ADDR) && (offset <= OFF_STATUS);
   assign rd_hit = hit && !BUS_WE;
   assign wr_hit = hit && BUS_WE;

   // Read mux over the pre-edge register values.
   always_comb begin
      rd_val = 8'h00;
      for (int i = 0; i < NUM_BYTES; i++) begin
         if (offset == 8'(i)) begin
            rd_val = data_q[i];
         end
      end
      if (offset == OFF_BLINK) begin
         rd_val = 8'(blink_en_q);
      end
      if (offset == OFF_STATUS) begin
         rd_val = {7'b0, phase_q};
      end
   end

   // Data and blink-enable registers.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < NUM_BYTES; i++) begin
            data_q[i] <= RESET_PATTERN;
         end
         blink_en_q <= '0;
      end else if (wr_hit) begin
         for (int i = 0; i < NUM_BYTES; i++) begin
            if (offset == 8'(i)) begin
               data_q[i] <= BUS_DATA;
            end
         end
         if (offset == OFF_BLINK) begin
            blink_en_q <= BUS_DATA[NUM_BYTES-1:0];
         end
      end
   end

   // Blink timebase. A STATUS write restarts the half-period in the "on"
   // phase and takes priority over a wrap on the same edge.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt_q   <= '0;
         phase_q <= 1'b1;
      end else if (wr_hit && offset == OFF_STATUS) begin
         cnt_q   <= '0;
         phase_q <= 1'b1;
      end else if (cnt_q == CNT_LAST) begin
         cnt_q   <= '0;
         phase_q <= ~phase_q;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Read port: the latch captures on every read hit; output-enable stays up
   // only across consecutive read hits.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         rd_latch_q <= 8'h00;
         oe_q       <= 1'b0;
      end else if (rd_hit) begin
         rd_latch_q <= rd_val;
         oe_q       <= 1'b1;
      end else begin
         oe_q <= 1'b0;
      end
   end

   // LED outputs lag register writes by one edge since they use pre-edge state.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         LEDs <= '0;
      end else begin
         for (int i = 0; i < NUM_BYTES; i++) begin
            LEDs[8*i +: 8] <= (blink_en_q[i] && !phase_q) ? 8'h00 : data_q[i];
         end
      end
   end

   // Reset clears oe_q asynchronously, which releases the bus immediately.
   assign BUS_DATA = oe_q ? rd_latch_q : 8'hzz;

endmodule

// File: tb/tb_io_bus_led_bank.sv
// tb/tb_io_bus_led_bank.sv - self-checking bench for io_bus_led_bank
module tb_io_bus_led_bank;

   localparam int         DIV  = 4;
   localparam int         NB   = 2;
   localparam logic [7:0] BASE = 8'hC0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  addr;
   logic        we;
   logic        tb_drv;
   logic [7:0]  tb_val;
   wire  [7:0]  bus_data;
   wire  [15:0] leds;

   int total = 0;
   int bad   = 0;

   logic [7:0]  m_data [NB];
   logic [1:0]  m_be;
   int          m_t;
   logic [15:0] exp_leds;
   logic        exp_oe;
   logic [7:0]  exp_bus;

   logic [7:0]  r1, r2;

   assign bus_data = tb_drv ? tb_val : 8'hzz;

   always #5 clk = ~clk;

   io_bus_led_bank #(
      .BASE_ADDR    (BASE),
      .NUM_BYTES    (NB),
      .BLINK_DIV    (DIV),
      .RESET_PATTERN(8'hA0)
   ) dut (
      .CLK     (clk),
      .RESET_N (rst_n),
      .BUS_DATA(bus_data),
      .BUS_ADDR(addr),
      .BUS_WE  (we),
      .LEDs    (leds)
   );

   // Phase follows from elapsed edges since the last restart: "on" during
   // even half-periods.
   function automatic logic m_phase();
      return ((m_t / DIV) % 2) == 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NB; i++) m_data[i] = 8'hA0;
      m_be     = 2'b00;
      m_t      = 0;
      exp_leds = 16'h0000;
      exp_oe   = 1'b0;
      exp_bus  = 8'h00;
   endtask

   task automatic model_step(input logic [7:0] a, input logic w, input logic [7:0] d);
      logic ph;
      logic h;
      int   o;
      ph = m_phase();
      for (int i = 0; i < NB; i++)
         exp_leds[8*i +: 8] = (m_be[i] && !ph) ? 8'h00 : m_data[i];
      h = (int'(a) >= int'(BASE)) && (int'(a) <= int'(BASE) + NB + 1);
      o = int'(a) - int'(BASE);
      exp_oe = h && !w;
      if (exp_oe) begin
         if (o < NB)       exp_bus = m_data[o];
         else if (o == NB) exp_bus = {6'b0, m_be};
         else              exp_bus = {7'b0, ph};
      end
      if (h && w && o == NB + 1) m_t = 0;
      else                       m_t = m_t + 1;
      if (h && w && o < NB)  m_data[o] = d;
      if (h && w && o == NB) m_be = d[1:0];
   endtask

   // One bus cycle; a write never directly follows a read hit so the two
   // drivers do not overlap on the sampling edge.
   task automatic cycle(input logic [7:0] a, input logic w, input logic [7:0] d);
      if (w && exp_oe) begin
         @(negedge clk);
         addr = 8'h00; we = 1'b0; tb_drv = 1'b0;
         @(posedge clk);
         model_step(8'h00, 1'b0, 8'h00);
      end
      @(negedge clk);
      addr = a; we = w; tb_drv = w; tb_val = d;
      @(posedge clk);
      model_step(a, w, d);
      #1;
   endtask

   // Drive two patterns onto the bus and read them back; both survive only
   // when nothing else drives the bus.
   task automatic bus_probe(output logic [7:0] p1, output logic [7:0] p2);
      logic       sd;
      logic [7:0] sv;
      sd = tb_drv; sv = tb_val;
      tb_drv = 1'b1; tb_val = 8'h3C;
      #1 p1 = bus_data;
      tb_val = 8'hC3;
      #1 p2 = bus_data;
      tb_drv = sd; tb_val = sv;
   endtask

   task automatic test_reset();
      #1;
      total++;
      if (leds !== 16'h0000) begin bad++; $display("FAIL reset_leds got=%h exp=0000", leds); end
      bus_probe(r1, r2);
      total++;
      if (r1 !== 8'h3C || r2 !== 8'hC3) begin bad++; $display("FAIL reset_bus_z got=%h/%h exp=3c/c3", r1, r2); end
      @(posedge clk);
      #2 rst_n = 1'b1;
      cycle(8'h00, 1'b0, 8'h00);
      total++;
      if (leds !== 16'hA0A0) begin bad++; $display("FAIL first_edge_leds got=%h exp=a0a0", leds); end
      bus_probe(r1, r2);
      total++;
      if (r1 !== 8'h3C || r2 !== 8'hC3) begin bad++; $display("FAIL idle_bus_z got=%h/%h exp=3c/c3", r1, r2); end
      cycle(BASE + 8'd3, 1'b0, 8'h00);
      total++;
      if (bus_data !== 8'h01 || exp_bus !== 8'h01) begin bad++; $display("FAIL status_reset got=%h exp=01", bus_data); end
   endtask

   task automatic test_write_read();
      cycle(BASE + 8'd1, 1'b1, 8'h5A);
      total++;
      if (leds !== exp_leds) begin bad++; $display("FAIL wr_edge_leds got=%h exp=%h", leds, exp_leds); end
      cycle(BASE + 8'd1, 1'b0, 8'h00);
      total++;
      if (leds !== 16'h5AA0) begin bad++; $display("FAIL wr_lag_leds got=%h exp=5aa0", leds); end
      total++;
      if (bus_data !== 8'h5A) begin bad++; $display("FAIL rd_data1 got=%h exp=5a", bus_data); end
      cycle(BASE + 8'd4, 1'b0, 8'h00);
      bus_probe(r1, r2);
      total++;
      if (r1 !== 8'h3C || r2 !== 8'hC3) begin bad++; $display("FAIL miss_bus_z got=%h/%h exp=3c/c3", r1, r2); end
      cycle(BASE - 8'd1, 1'b1, 8'h77);
      cycle(BASE + 8'd0, 1'b0, 8'h00);
      total++;
      if (bus_data !== 8'hA0) begin bad++; $display("FAIL miss_write_ignored got=%h exp=a0", bus_data); end
   endtask

   task automatic test_blink();
      int n_off, n_on;
      cycle(BASE + 8'd2, 1'b1, 8'hFF);
      cycle(BASE + 8'd2, 1'b0, 8'h00);
      total++;
      if (bus_data !== 8'h03) begin bad++; $display("FAIL blink_en_read got=%h exp=03", bus_data); end
      n_off = 0; n_on = 0;
      for (int k = 0; k < 16; k++) begin
         cycle(8'h10, 1'b0, 8'h00);
         total++;
         if (leds !== exp_leds) begin bad++; $display("FAIL blink_leds cyc=%0d got=%h exp=%h", k, leds, exp_leds); end
         if (leds === 16'h0000) n_off++;
         if (leds === 16'h5AA0) n_on++;
      end
      total++;
      if (n_off != 8 || n_on != 8) begin bad++; $display("FAIL blink_duty got=%0d/%0d exp=8/8", n_off, n_on); end
   endtask

   task automatic test_restart();
      int guard;
      guard = 0;
      while ((m_t % DIV) != DIV - 1 && guard < 16) begin
         cycle(8'h10, 1'b0, 8'h00);
         guard++;
      end
      total++;
      if (guard >= 16) begin bad++; $display("FAIL wrap_wait got=timeout exp=wrap"); end
      cycle(BASE + 8'd3, 1'b1, 8'h00);
      cycle(BASE + 8'd3, 1'b0, 8'h00);
      total++;
      if (bus_data !== 8'h01) begin bad++; $display("FAIL restart_phase got=%h exp=01", bus_data); end
      for (int k = 0; k < 8; k++) begin
         cycle(8'h10, 1'b0, 8'h00);
         total++;
         if (leds !== exp_leds) begin bad++; $display("FAIL restart_leds cyc=%0d got=%h exp=%h", k, leds, exp_leds); end
      end
      guard = 0;
      while (m_phase() && guard < 16) begin
         cycle(8'h10, 1'b0, 8'h00);
         guard++;
      end
      cycle(BASE + 8'd2, 1'b1, 8'h00);
      total++;
      if (leds !== 16'h0000) begin bad++; $display("FAIL off_before_clear got=%h exp=0000", leds); end
      cycle(8'h10, 1'b0, 8'h00);
      total++;
      if (leds !== 16'h5AA0) begin bad++; $display("FAIL clear_restore got=%h exp=5aa0", leds); end
   endtask

   task automatic test_random();
      logic [7:0] a, d;
      logic       w;
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 7) == 0) a = 8'($urandom);
         else a = BASE - 8'd1 + 8'($urandom_range(0, 5));
         w = 1'($urandom);
         d = 8'($urandom);
         cycle(a, w, d);
         total++;
         if (leds !== exp_leds) begin bad++; $display("FAIL rnd_leds cyc=%0d got=%h exp=%h", k, leds, exp_leds); end
         if (exp_oe) begin
            total++;
            if (bus_data !== exp_bus) begin bad++; $display("FAIL rnd_bus cyc=%0d got=%h exp=%h", k, bus_data, exp_bus); end
         end else if ((k % 4) == 0) begin
            bus_probe(r1, r2);
            total++;
            if (r1 !== 8'h3C || r2 !== 8'hC3) begin bad++; $display("FAIL rnd_bus_z cyc=%0d got=%h/%h exp=3c/c3", k, r1, r2); end
         end
      end
   endtask

   task automatic test_async_reset();
      cycle(BASE + 8'd1, 1'b1, 8'h3E);
      cycle(BASE + 8'd0, 1'b1, 8'h81);
      cycle(BASE + 8'd0, 1'b0, 8'h00);
      total++;
      if (bus_data !== 8'h81) begin bad++; $display("FAIL pre_reset_read got=%h exp=81", bus_data); end
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      total++;
      if (leds !== 16'h0000) begin bad++; $display("FAIL async_leds got=%h exp=0000", leds); end
      bus_probe(r1, r2);
      total++;
      if (r1 !== 8'h3C || r2 !== 8'hC3) begin bad++; $display("FAIL async_bus_z got=%h/%h exp=3c/c3", r1, r2); end
      @(posedge clk);
      #2 rst_n = 1'b1;
      cycle(8'h00, 1'b0, 8'h00);
      total++;
      if (leds !== 16'hA0A0) begin bad++; $display("FAIL post_reset_leds got=%h exp=a0a0", leds); end
      for (int o = 0; o < 4; o++) begin
         cycle(BASE + 8'(o), 1'b0, 8'h00);
         total++;
         if (bus_data !== exp_bus) begin bad++; $display("FAIL post_reset_reg%0d got=%h exp=%h", o, bus_data, exp_bus); end
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      addr   = 8'h00;
      we     = 1'b0;
      tb_drv = 1'b0;
      tb_val = 8'h00;
      model_reset();
      test_reset();
      test_write_read();
      test_blink();
      test_restart();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/io_bus_led_bank.md
IO_BUS_LED_BANK -- requirements
Module: io_bus_led_bank

Interface
REQ-001 Parameter BASE_ADDR, default 8'hC0, first bus address of the register window.
REQ-002 Parameter NUM_BYTES, default 2, number of 8-bit LED data registers; legal range 1..8.
REQ-003 Parameter BLINK_DIV, default 25000000, clock cycles per blink half-period; legal minimum 2.
REQ-004 Parameter RESET_PATTERN, default 8'hA0, reset value of every LED data register.
REQ-005 Parameter legality SHALL hold: BASE_ADDR+NUM_BYTES+1 <= 8'hFF.
REQ-006 CLK  input  1  single clock; all state changes on rising edge.
REQ-007 RESET_N  input  1  asynchronous, active-low reset.
REQ-008 BUS_DATA  inout  8  shared tri-state data bus.
REQ-009 BUS_ADDR  input  8  bus address.
REQ-010 BUS_WE  input  1  high = CPU write cycle; low = read cycle.
REQ-011 LEDs  output  8*NUM_BYTES  registered LED drive; byte i at bits [8i+7:8i].

Function
REQ-012 Window: offset o = BUS_ADDR-BASE_ADDR; hit when BASE_ADDR <= BUS_ADDR <= BASE_ADDR+NUM_BYTES+1; no state change and no bus drive outside the window.
REQ-013 Offsets 0..NUM_BYTES-1 SHALL be DATA[o], read/write.
REQ-014 Offset NUM_BYTES SHALL be BLINK_EN: bit i enables blink of byte i; bits >= NUM_BYTES read 0, writes to them ignored.
REQ-015 Offset NUM_BYTES+1 SHALL be STATUS: read = {7'b0, phase}; any write = blink restart (counter <= 0, phase <= 1).
REQ-016 Write: hit with BUS_WE=1 at edge k SHALL update the addressed register at edge k; bus not driven.
REQ-017 Read: hit with BUS_WE=0 at edge k SHALL register the addressed value into an output latch and set output-enable; BUS_DATA driven from after edge k until the first edge with no read hit.
REQ-018 Output-enable SHALL be cleared at any edge without a read hit (write, miss); BUS_DATA = 8'hZZ whenever disabled.
REQ-019 Blink counter: increments each cycle; at count BLINK_DIV-1 it SHALL wrap to 0 and toggle phase at the same edge (phase period = 2*BLINK_DIV cycles).
REQ-020 STATUS write coinciding with counter wrap: restart wins (counter 0, phase 1).
REQ-021 LEDs byte i SHALL update every edge: 8'h00 if BLINK_EN[i]=1 and phase=0, else DATA[i]; uses pre-edge register values (one-cycle lag after a write).
REQ-022 Clearing BLINK_EN[i] SHALL restore DATA[i] on LEDs at the next edge regardless of phase.
REQ-023 Counter width SHALL be ceil(log2(BLINK_DIV)); no overflow beyond BLINK_DIV-1.

Reset
REQ-024 RESET_N=0 SHALL immediately: DATA[all] = RESET_PATTERN, BLINK_EN = 0, counter = 0, phase = 1, LEDs = 0, output-enable = 0 (BUS_DATA = Z), output latch = 0.
REQ-025 Reset asserted mid-read SHALL release BUS_DATA asynchronously, without waiting for a clock edge.
REQ-026 First edge after RESET_N rises SHALL drive LEDs = RESET_PATTERN replicated per byte.

Verification (NUM_BYTES=2, BLINK_DIV=4, BASE_ADDR=8'hC0, RESET_PATTERN=8'hA0)
REQ-027 Reset release, one idle cycle -> LEDs = 16'hA0A0, BUS_DATA = Z, read C3 -> 8'h01.
REQ-028 Write C1=8'h5A, then read C1 -> bus 8'h5A one cycle after address; LEDs = 16'h5AA0 one edge after write; read C4 (miss) -> bus Z.
REQ-029 Write C2=8'hFF, observe 16 cycles -> BLINK_EN reads 8'h03; LEDs alternate 16'h0000 / 16'h5AA0 every 4 cycles, starting at phase 1.
REQ-030 While blinking, write C3 at the wrap cycle -> phase reads 1, next LEDs-off transition exactly 4 cycles later; write C2=0 during off phase -> LEDs restored next edge.
REQ-031 Assert RESET_N=0 during a read of C0 without clock edge -> BUS_DATA goes Z, LEDs = 0 immediately; after release all registers at reset values.
